bus_router: RTL
===============

# bus_router

Single-master, multi-slave request router sitting directly downstream of the address decoder on the system bus. Takes a master request plus the decoder's `tag` and `addr_masked`, forwards the request to the one slave selected by `tag`, waits for that slave's response and returns it to the master. Exactly one transaction is outstanding at a time. An optional timeout turns a hung slave into an error response.

## Interface
- `AddrWidth`, default 32: address width, same as the decoder.
- `TagWidth`, default 2: tag width; `NumSlaves = 2**TagWidth` (localparam).
- `WordWidth`, default 32: data width; `BeWidth = WordWidth/8` (localparam).
- `TimeoutCycles`, default 255: REQ+WAIT cycles before an error response; must be ≥ 2. Used only with `BUS_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m_req_valid` in 1: master request valid.
- `m_req_ready` out 1: router can accept a request.
- `m_we` in 1: write enable.
- `m_wdata` in WordWidth: write data.
- `m_be` in BeWidth: byte enables.
- `dec_tag` in TagWidth: slave select, from the decoder.
- `dec_addr_masked` in AddrWidth: slave-local address, from the decoder.
- `m_rsp_valid` out 1: one-cycle response strobe.
- `m_rsp_rdata` out WordWidth: read data.
- `m_rsp_err` out 1: error (timeout).
- `s_req_valid` out NumSlaves: per-slave request valid, one-hot or zero.
- `s_req_ready` in NumSlaves: per-slave accept.
- `s_addr` out AddrWidth: shared slave address.
- `s_we` out 1: shared write enable.
- `s_wdata` out WordWidth: shared write data.
- `s_be` out BeWidth: shared byte enables.
- `s_rsp_valid` in NumSlaves: per-slave response valid.
- `s_rsp_rdata` in NumSlaves*WordWidth: slave i occupies bits `[i*WordWidth +: WordWidth]`.

## Operation
- States: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- Reset values: all registers 0; `s_req_valid` 0; `m_rsp_valid` 0; `m_rsp_rdata` 0; `m_rsp_err` 0; `s_addr`, `s_we`, `s_wdata`, `s_be` 0.
- `m_req_ready = (state==IDLE) && !rst`.
- **IDLE:** when `m_req_valid && m_req_ready`, latch `dec_tag`, `dec_addr_masked`, `m_we`, `m_wdata`, `m_be`, clear the timeout counter, then go to REQ. Master inputs are ignored in every other state.
- **REQ:**
  - Drive `s_req_valid[tag]=1`, all other bits 0. `s_addr`, `s_we`, `s_wdata` and `s_be` hold the latched values (they hold through WAIT and RESP).
  - On `s_req_ready[tag]`, go to WAIT.
  - If `s_rsp_valid[tag]` is also high in that cycle, capture the data and go straight to RESP.
- **WAIT:** `s_req_valid=0`. On `s_rsp_valid[tag]`, capture `s_rsp_rdata` slice `tag`, set `err=0`, go to RESP.
- **RESP:** `m_rsp_valid=1` for exactly one cycle, with registered `m_rsp_rdata` and `m_rsp_err`. Then go to IDLE. The master always accepts; there is no response back-pressure.
- Ignored inputs:
  - `s_rsp_valid` from non-selected slaves, in all states.
  - `s_rsp_valid[tag]` while in REQ before `s_req_ready[tag]`.
  - Any slave response in IDLE or RESP.
- `m_rsp_rdata` and `m_rsp_err` hold their values until the next capture. Their value outside RESP is don't-care for the master.
- Reset mid-transaction returns to IDLE immediately. `s_req_valid` drops asynchronously and the in-flight transaction is lost.

## Timing
- Request accepted in cycle 0 → `s_req_valid` high in cycle 1.
- Minimum latency: slave ready and response both in cycle 1 → `m_rsp_valid` in cycle 2 → `m_req_ready` high again in cycle 3.
- Back-to-back throughput is at most one transaction per 3 cycles.
- Timeout counter:
  - Increments every cycle spent in REQ or WAIT.
  - If the count reaches `TimeoutCycles-1` in a cycle with no completion, go to RESP with `err=1` and `rdata=0`. `m_rsp_valid` then appears in cycle `TimeoutCycles+1`.
  - A completion in the same cycle as expiry wins: normal response, `err=0`.
  - A timeout in REQ withdraws `s_req_valid`.
- Counter width is `$clog2(TimeoutCycles+1)`; it saturates and never wraps.

## Configuration
- Macro `BUS_TIMEOUT_EN`.
- Defined: timeout counter and error path are present, as described above.
- Undefined:
  - No counter; REQ and WAIT wait indefinitely.
  - `m_rsp_err` is tied to 0.
  - `TimeoutCycles` is unused.

## Test plan
- **Read, zero-wait slave:** tag=2, addr_masked=0x0000_0010; slave 2 asserts ready and rsp with rdata 0xDEADBEEF in cycle 1 → `s_req_valid=4'b0100` in cycle 1 only; `m_rsp_valid` in cycle 2 with rdata 0xDEADBEEF, err 0; `m_req_ready` high in cycle 3.
- **Write with stalls:** tag=1, we=1, wdata 0x12345678, be 4'b0011; slave 1 ready after 3 cycles, rsp 2 cycles later → `s_*` fields hold throughout; exactly one `m_rsp_valid` pulse, err 0.
- **Stray responses:** while waiting on tag=0, slave 3 pulses `s_rsp_valid` with 0xFFFFFFFF → ignored; slave 0's later response 0x00000001 is returned.
- **Timeout (`BUS_TIMEOUT_EN`, TimeoutCycles=8), silent slave:** `m_rsp_valid` in cycle 9 with err 1, rdata 0; `s_req_valid` is 0 from cycle 9. Second case: completion exactly at expiry → err 0.
- **Reset in WAIT:** assert `rst` → `s_req_valid` and `m_rsp_valid` are 0 at once; after release the next request completes normally. Without `BUS_TIMEOUT_EN`, a silent slave keeps the router in WAIT for 1000 cycles with no response.

Source files
------------

// File: rtl/bus_router.sv
`default_nettype none
// ============================================================================
// Module   : bus_router
// Purpose  : Routes one master request at a time to the slave chosen by the
//            decoder tag and returns that slave's response.
//            Optional timeout error path: define BUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_router #(
  parameter int AddrWidth     = 32,
  parameter int TagWidth      = 2,
  parameter int WordWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m_req_valid,
  output logic                             m_req_ready,
  input  logic                             m_we,
  input  logic [WordWidth-1:0]             m_wdata,
  input  logic [WordWidth/8-1:0]           m_be,
  input  logic [TagWidth-1:0]              dec_tag,
  input  logic [AddrWidth-1:0]             dec_addr_masked,
  output logic                             m_rsp_valid,
  output logic [WordWidth-1:0]             m_rsp_rdata,
  output logic                             m_rsp_err,
  output logic [(2**TagWidth)-1:0]         s_req_valid,
  input  logic [(2**TagWidth)-1:0]         s_req_ready,
  output logic [AddrWidth-1:0]             s_addr,
  output logic                             s_we,
  output logic [WordWidth-1:0]             s_wdata,
  output logic [WordWidth/8-1:0]           s_be,
  input  logic [(2**TagWidth)-1:0]         s_rsp_valid,
  input  logic [(2**TagWidth)*WordWidth-1:0] s_rsp_rdata
);

  localparam int NumSlaves = 2**TagWidth;
  localparam int BeWidth   = WordWidth/8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                 r_state;
  logic [TagWidth-1:0]    r_tag;
  logic [AddrWidth-1:0]   r_addr;
  logic                   r_we;
  logic [WordWidth-1:0]   r_wdata;
  logic [BeWidth-1:0]     r_be;
  logic [WordWidth-1:0]   r_rdata;

  logic                   w_sel_ready;
  logic                   w_sel_rsp;
  logic [WordWidth-1:0]   w_sel_rdata;
  logic                   w_expired;

  if (TimeoutCycles < 2) begin : g_timeout_check
    $error("bus_router: TimeoutCycles must be >= 2");
  end

  assign w_sel_ready = s_req_ready[r_tag];
  assign w_sel_rsp   = s_rsp_valid[r_tag];
  assign w_sel_rdata = s_rsp_rdata[r_tag*WordWidth +: WordWidth];

`ifdef BUS_TIMEOUT_EN
  localparam int CntWidth = $clog2(TimeoutCycles+1);

  logic [CntWidth-1:0] r_cnt;
  logic                r_err;

  assign w_expired = (r_cnt >= CntWidth'(TimeoutCycles-1));

  // Counts cycles spent in REQ/WAIT; saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == REQ || r_state == WAIT) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign m_rsp_err = r_err;
`else
  assign w_expired = 1'b0;
  assign m_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tag   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (m_req_valid) begin
            r_tag   <= dec_tag;
            r_addr  <= dec_addr_masked;
            r_we    <= m_we;
            r_wdata <= m_wdata;
            r_be    <= m_be;
            r_state <= REQ;
          end
        end
        REQ: begin
          // A completion always beats a simultaneous expiry.
          if (w_sel_ready && w_sel_rsp) begin
            r_rdata <= w_sel_rdata;
`ifdef BUS_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            r_state <= RESP;
          end else if (w_expired) begin
            r_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            r_err   <= 1'b1;
`endif
            r_state <= RESP;
          end else if (w_sel_ready) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_sel_rsp) begin
            r_rdata <= w_sel_rdata;
`ifdef BUS_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            r_state <= RESP;
          end else if (w_expired) begin
            r_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            r_err   <= 1'b1;
`endif
            r_state <= RESP;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Decoded from the async-reset state so s_req_valid drops the moment rst rises.
  assign s_req_valid = (r_state == REQ) ? (NumSlaves'(1) << r_tag) : '0;
  assign m_req_ready = (r_state == IDLE) && !rst;
  assign m_rsp_valid = (r_state == RESP);
  assign m_rsp_rdata = r_rdata;
  assign s_addr      = r_addr;
  assign s_we        = r_we;
  assign s_wdata     = r_wdata;
  assign s_be        = r_be;

endmodule
`default_nettype wire
